// File: rtl/prog_flag_counter.sv
// prog_flag_counter
//   Programmable terminal-count counter with a one-cycle flag pulse per
//   terminal event, a one-shot / auto-reload mode, and a saturating count of
//   flag events.
//
// Ports
//   clk_p       in   rising-edge clock for all logic
//   rst         in   synchronous active-high reset (term returns to DEF_TERM)
//   enable      in   count qualifier
//   clear       in   soft clear of count/state/flag/total (term kept)
//   load        in   writes load_val into the terminal register, zeroes count
//   load_val    in   [WIDTH] new terminal value
//   mode        in   0 = one-shot (stop in HOLD), 1 = auto-reload
//   count       out  [WIDTH] current count, 0..term
//   flag_count  out  one-cycle pulse after each terminal-count step
//   busy        out  high while in RUN
//   done        out  high while in HOLD
//   flag_total  out  [WIDTH] saturating number of flag events
module prog_flag_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEF_TERM = 9
) (
  input  logic             clk_p,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             flag_count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] flag_total
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] r_total;
  logic             r_flag;

  state_t           w_nxt_state;
  logic [WIDTH-1:0] w_nxt_count;
  logic [WIDTH-1:0] w_nxt_term;
  logic [WIDTH-1:0] w_nxt_total;
  logic             w_nxt_flag;

  logic             w_hit;
  logic [WIDTH-1:0] w_step_count;
  logic [WIDTH-1:0] w_total_inc;

  // Count step helpers: wrap to zero on terminal, saturate the event total.
  assign w_hit        = (r_count == r_term);
  assign w_step_count = w_hit ? '0 : r_count + WIDTH'(1);
  assign w_total_inc  = (r_total == '1) ? r_total : r_total + WIDTH'(1);

  always_ff @(posedge clk_p) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_term  <= WIDTH'(DEF_TERM);
      r_total <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_count <= w_nxt_count;
      r_term  <= w_nxt_term;
      r_total <= w_nxt_total;
      r_flag  <= w_nxt_flag;
    end
  end

  // Priority below reset: clear > load > enable.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_count = r_count;
    w_nxt_term  = r_term;
    w_nxt_total = r_total;
    w_nxt_flag  = 1'b0;

    if (clear) begin
      w_nxt_state = S_IDLE;
      w_nxt_count = '0;
      w_nxt_total = '0;
    end else if (load) begin
      // Zeroing count here keeps count <= term when term shrinks.
      w_nxt_term  = load_val;
      w_nxt_count = '0;
      w_nxt_state = (r_state == S_RUN) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (enable) begin
            w_nxt_count = w_step_count;
            if (w_hit) begin
              w_nxt_flag  = 1'b1;
              w_nxt_total = w_total_inc;
              w_nxt_state = mode ? S_RUN : S_HOLD;
            end else begin
              w_nxt_state = S_RUN;
            end
          end
        end
        S_HOLD: begin
          w_nxt_count = '0;
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registers or pure decodes of the state register.
  assign count      = r_count;
  assign flag_count = r_flag;
  assign flag_total = r_total;
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_HOLD);

endmodule

// File: tb/tb_prog_flag_counter.sv
// Scoreboard bench for prog_flag_counter (WIDTH=8, DEF_TERM=9).
// The stimulus process drives inputs at the falling edge and queues the
// hand-computed outputs expected after the next rising edge; the monitor pops
// one entry per rising edge and compares.
module tb_prog_flag_counter;

  logic       clk_p = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       mode = 1'b0;
  logic [7:0] count;
  logic       flag_count;
  logic       busy;
  logic       done;
  logic [7:0] flag_total;

  prog_flag_counter #(.WIDTH(8), .DEF_TERM(9)) dut (
    .clk_p      (clk_p),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .mode       (mode),
    .count      (count),
    .flag_count (flag_count),
    .busy       (busy),
    .done       (done),
    .flag_total (flag_total)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    logic [7:0] cnt;
    logic       flg;
    logic       bsy;
    logic       dne;
    logic [7:0] tot;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
  endtask

  // Monitor: one output sample per rising edge while entries are pending.
  always @(posedge clk_p) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "count", int'(count), int'(e.cnt));
      chk(e.nm, "flag", int'(flag_count), int'(e.flg));
      chk(e.nm, "busy", int'(busy), int'(e.bsy));
      chk(e.nm, "done", int'(done), int'(e.dne));
      chk(e.nm, "total", int'(flag_total), int'(e.tot));
    end
  end

  task automatic cyc(input logic rs, input logic en, input logic clr, input logic ld,
                     input logic [7:0] lv, input logic md,
                     input logic [7:0] ec, input logic ef, input logic eb,
                     input logic ed, input logic [7:0] et, input string nm);
    exp_t e;
    @(negedge clk_p);
    rst = rs; enable = en; clear = clr; load = ld; load_val = lv; mode = md;
    e.cnt = ec; e.flg = ef; e.bsy = eb; e.dne = ed; e.tot = et; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    // Reset for two cycles.
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset");

    // Auto-reload free run: 1..9,0 with a flag every 10th cycle.
    for (int k = 1; k <= 30; k++)
      cyc(0, 1, 0, 0, 0, 1, 8'(k % 10), (k % 10) == 0, 1, 0, 8'(k / 10), "autorun");

    // One-shot: single flag after 10 enabled cycles, then parked in HOLD.
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clear1");
    for (int k = 1; k <= 10; k++)
      cyc(0, 1, 0, 0, 0, 0, 8'(k % 10), k == 10, k != 10, k == 10, 8'(k / 10), "oneshot");
    for (int k = 0; k < 20; k++)
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "hold");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clear2");

    // Enable toggled: count advances only on enabled cycles.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      bit en;
      en = (i % 2) == 0;
      if (en) n++;
      cyc(0, en, 0, 0, 0, 1, 8'(n % 10), en && (n % 10) == 0, 1, 0, 8'(n / 10), "toggle");
    end
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "clear3");

    // Load term=3 at count=5 with enable high: no step, count zeroed.
    for (int k = 1; k <= 5; k++)
      cyc(0, 1, 0, 0, 0, 1, 8'(k), 0, 1, 0, 0, "pre_load");
    cyc(0, 1, 0, 1, 8'd3, 1, 0, 0, 1, 0, 0, "load_run");
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, "term3_a");
    cyc(0, 1, 0, 0, 0, 1, 2, 0, 1, 0, 0, "term3_b");
    cyc(0, 1, 0, 0, 0, 1, 3, 0, 1, 0, 0, "term3_c");
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, "term3_flag");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, "run_idle_en");
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "clear4");

    // term=0: flag every enabled cycle, total saturates at 255.
    cyc(0, 0, 0, 1, 8'd0, 1, 0, 0, 0, 0, 0, "load_zero");
    for (int k = 1; k <= 256; k++)
      cyc(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, (k > 255) ? 8'd255 : 8'(k), "term0");
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, "clear5");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "idle_after_clr");

    // One-shot with term=0 from IDLE goes straight to HOLD; load exits HOLD.
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, "oneshot_t0");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "hold_t0");
    cyc(0, 1, 0, 1, 8'd9, 0, 0, 0, 0, 0, 1, "load_hold");

    // Reset at count=9 with enable high: no flag, term back to default.
    for (int k = 1; k <= 9; k++)
      cyc(0, 1, 0, 0, 0, 1, 8'(k), 0, 1, 0, 1, "pre_rst");
    cyc(1, 1, 1, 1, 8'd2, 1, 0, 0, 0, 0, 0, "rst_mid");
    for (int k = 1; k <= 10; k++)
      cyc(0, 1, 0, 0, 0, 1, 8'(k % 10), k == 10, 1, 0, 8'(k / 10), "post_rst");

    @(negedge clk_p);
    enable = 1'b0;
    @(negedge clk_p);
    stim_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (stim_done);
        @(posedge clk_p);
        #2;
      end
      begin
        #100000;
        $display("FAIL watchdog actual=timeout required=stimulus_complete");
        n_checks++;
      end
    join_any
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_flag_counter.md
PROG_FLAG_COUNTER -- requirements
Module: prog_flag_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of count, terminal value and event total.
REQ-002 Parameter DEF_TERM, default 9: terminal value loaded at reset; the counter covers 0..term, so there are term+1 enabled cycles per period.
REQ-003 clk_p  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  count qualifier, sampled each rising edge.
REQ-006 clear  input  1  synchronous soft clear of count/state/flag/total; term untouched.
REQ-007 load  input  1  strobe, writes load_val into term register.
REQ-008 load_val  input  WIDTH  new terminal value.
REQ-009 mode  input  1  0 = one-shot, 1 = auto-reload; sampled at terminal-count cycle.
REQ-010 count  output  WIDTH  current count, registered.
REQ-011 flag_count  output  1  one-cycle pulse per terminal-count event, registered.
REQ-012 busy  output  1  high in RUN, low in IDLE/HOLD.
REQ-013 done  output  1  high while in HOLD.
REQ-014 flag_total  output  WIDTH  number of flag events since reset/clear, saturating.

Function
REQ-015 The FSM shall have states IDLE, RUN and HOLD, encoded in 2 bits; the unused encoding shall return to IDLE on the next edge.
REQ-016 Input priority per edge: rst > clear > load > enable.
REQ-017 IDLE, enable=1: perform the count step (REQ-019/020); state -> RUN, unless the step hits terminal in one-shot mode, in which case state -> HOLD.
REQ-018 RUN, enable=0: count, state and flag_total hold; flag_count = 0 next cycle.
REQ-019 Count step when count != term: count <= count+1, flag_count <= 0.
REQ-020 Count step when count == term:
- count <= 0 and flag_count <= 1 for exactly one cycle.
- flag_total <= flag_total+1, saturating at 2^WIDTH-1.
- Next state: mode=1 stays RUN; mode=0 goes to HOLD.
REQ-021 Flag latency: flag_count shall be high in the cycle immediately after the edge at which enable=1 was sampled with count==term.
REQ-022 term=0: every enabled cycle is a terminal event; count stays 0, flag_count is high every cycle following an enabled cycle in auto-reload.
REQ-023 HOLD: enable is ignored; count=0, done=1, busy=0; only clear, load or rst exit HOLD.
REQ-024 load=1:
- term <= load_val; count <= 0; flag_count <= 0.
- No count step that cycle, even if enable=1.
- HOLD goes to IDLE; RUN stays RUN; IDLE stays IDLE.
REQ-025 clear=1: count <= 0, flag_count <= 0, flag_total <= 0, state <= IDLE; term keeps its value.
REQ-026 count shall never exceed term; if term is loaded below count, count is zeroed by the same load (REQ-024).
REQ-027 All outputs shall be driven from registers; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 at a rising edge: count=0, flag_count=0, flag_total=0, term=DEF_TERM, state=IDLE, busy=0, done=0, visible after that edge.
REQ-029 Reset mid-operation shall abort any run with no flag pulse generated, regardless of enable, load or clear.

Verification
REQ-030 rst high 2 cycles, then enable=1 continuously, mode=1, WIDTH=8, DEF_TERM=9: count runs 1..9,0 repeating; flag_count pulses every 10th cycle; flag_total increments 1,2,3.
REQ-031 mode=0, enable=1 continuously: single flag_count pulse after 10 enabled cycles; done=1, busy=0, count held 0 for a further 20 cycles.
REQ-032 Enable toggled 1-0-1-0: count advances only on enabled cycles; flag arrives after exactly 10 enabled cycles.
REQ-033 In RUN at count=5, load=1 with load_val=3 and enable=1 in the same cycle: count=0, no increment; flag after the next 4 enabled cycles.
REQ-034 load_val=0, mode=1, enable=1: flag_count high every cycle; flag_total=255 after 255 events and stays 255 at event 256; clear sets flag_total=0 and state IDLE.
REQ-035 rst asserted at count=9 with enable=1: no flag pulse; all outputs take reset values on the next cycle; term returns to 9.
